// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer
//   Streams one tile of K operand steps from a ready/valid input into the row
//   and column lanes of an external mac_array, waits for the array pipeline to
//   settle, then drains the H*W results over a valid/yumi port.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   en_i                  global enable; low freezes all state, ready_o/valid_o = 0
//   flush_i               abort the current tile and clear the array
//   k_len_i, accum_i      tile depth and accumulate mode, sampled on first accept
//   valid_i/data_i/ready_o  operand input stream
//   row_*/col_*           per-lane operand handshakes (data replicated to all lanes)
//   mac_clear_o           one-cycle clear pulse to mac_array
//   z_i                   MAC results, word r*W+c at [(r*W+c+1)*width_p-1 -: width_p]
//   valid_o/data_o/last_o/yumi_i  result producer port
//   busy_o, state_o       status / debug
//
// Handshake rule (input, lanes and output alike): a transfer happens in a cycle
// where both valid and ready (yumi on the output side) are high; valid never
// depends on ready. Input handshakes are a zero-latency combinational
// pass-through to the lane currently selected by lane_r.
module systolic_tile_sequencer #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 8,
  parameter int array_height_p = 8,
  parameter int max_k_p        = 16,
  parameter int drain_lat_p    = 16
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic                                             en_i,
  input  logic                                             flush_i,
  input  logic [$clog2(max_k_p+1)-1:0]                     k_len_i,
  input  logic                                             accum_i,
  input  logic                                             valid_i,
  input  logic [width_p-1:0]                               data_i,
  output logic                                             ready_o,
  output logic [width_p*array_height_p-1:0]                row_o,
  output logic [array_height_p-1:0]                        row_valid_o,
  input  logic [array_height_p-1:0]                        row_ready_i,
  output logic [width_p*array_width_p-1:0]                 col_o,
  output logic [array_width_p-1:0]                         col_valid_o,
  input  logic [array_width_p-1:0]                         col_ready_i,
  output logic                                             mac_clear_o,
  input  logic [width_p*array_height_p*array_width_p-1:0]  z_i,
  output logic                                             valid_o,
  output logic [width_p-1:0]                               data_o,
  output logic                                             last_o,
  input  logic                                             yumi_i,
  output logic                                             busy_o,
  output logic [2:0]                                       state_o
);

  localparam int lanes_lp  = array_height_p + array_width_p;
  localparam int lane_w_lp = (lanes_lp > 1) ? $clog2(lanes_lp) : 1;
  localparam int k_w_lp    = $clog2(max_k_p + 1);
  localparam int wait_w_lp = $clog2(drain_lat_p + 1);
  localparam int words_lp  = array_height_p * array_width_p;
  localparam int out_w_lp  = (words_lp > 1) ? $clog2(words_lp) : 1;

  localparam logic [lane_w_lp-1:0] last_lane_lp = lane_w_lp'(lanes_lp - 1);
  localparam logic [wait_w_lp-1:0] last_wait_lp = wait_w_lp'(drain_lat_p - 1);
  localparam logic [out_w_lp-1:0]  last_word_lp = out_w_lp'(words_lp - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    CLEAR = 3'd4
  } state_e;

  state_e               state_r, state_n;
  logic [lane_w_lp-1:0] lane_r, lane_n;
  logic [k_w_lp-1:0]    k_r, k_n;
  logic [wait_w_lp-1:0] wait_r, wait_n;
  logic [out_w_lp-1:0]  out_r, out_n;
  logic [k_w_lp-1:0]    k_len_r, k_len_n;
  logic                 accum_r, accum_n;

  logic                 accepting, lane_valid, sel_ready, accept, yumi;
  logic [k_w_lp-1:0]    k_cur;
  logic [width_p-1:0]   word_sel;

  // 0 means a single step; anything above max_k_p saturates.
  function automatic logic [k_w_lp-1:0] sat_k(input logic [k_w_lp-1:0] k);
    if (k == '0) return k_w_lp'(1);
    if (k > k_w_lp'(max_k_p)) return k_w_lp'(max_k_p);
    return k;
  endfunction

  assign accepting  = en_i && (state_r == IDLE || state_r == LOAD);
  assign lane_valid = valid_i && accepting;
  assign ready_o    = accepting && sel_ready;
  assign accept     = valid_i && ready_o;
  assign valid_o    = en_i && (state_r == DRAIN);
  assign yumi       = yumi_i && valid_o;

  assign row_o = {array_height_p{data_i}};
  assign col_o = {array_width_p{data_i}};

  // The tile's first accept happens in IDLE, so it must use the incoming depth.
  assign k_cur = (state_r == IDLE) ? sat_k(k_len_i) : k_len_r;

  // Lane select: rows 0..H-1 first, then columns 0..W-1.
  always_comb begin
    row_valid_o = '0;
    col_valid_o = '0;
    sel_ready   = 1'b0;
    for (int r = 0; r < array_height_p; r++) begin
      if (lane_r == lane_w_lp'(r)) begin
        row_valid_o[r] = lane_valid;
        sel_ready      = row_ready_i[r];
      end
    end
    for (int c = 0; c < array_width_p; c++) begin
      if (lane_r == lane_w_lp'(array_height_p + c)) begin
        col_valid_o[c] = lane_valid;
        sel_ready      = col_ready_i[c];
      end
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < words_lp; i++) begin
      if (out_r == out_w_lp'(i)) word_sel = z_i[i*width_p +: width_p];
    end
  end

  assign data_o      = (state_r == DRAIN) ? word_sel : '0;
  assign last_o      = (state_r == DRAIN) && (out_r == last_word_lp);
  // Gated by en_i so a frozen CLEAR state does not stretch the pulse.
  assign mac_clear_o = en_i && (state_r == CLEAR);
  assign busy_o      = (state_r != IDLE);
  assign state_o     = state_r;

  always_comb begin
    state_n = state_r;
    lane_n  = lane_r;
    k_n     = k_r;
    wait_n  = wait_r;
    out_n   = out_r;
    k_len_n = k_len_r;
    accum_n = accum_r;

    case (state_r)
      IDLE, LOAD: begin
        if (accept) begin
          if (state_r == IDLE) begin
            k_len_n = k_cur;
            accum_n = accum_i;
          end
          state_n = LOAD;
          if (lane_r == last_lane_lp) begin
            lane_n = '0;
            if (k_r == k_cur - k_w_lp'(1)) begin
              k_n     = '0;
              state_n = WAIT;
            end else begin
              k_n = k_r + k_w_lp'(1);
            end
          end else begin
            lane_n = lane_r + lane_w_lp'(1);
          end
        end
      end
      WAIT: begin
        if (wait_r == last_wait_lp) begin
          wait_n  = '0;
          out_n   = '0;
          state_n = DRAIN;
        end else begin
          wait_n = wait_r + wait_w_lp'(1);
        end
      end
      DRAIN: begin
        if (yumi) begin
          if (out_r == last_word_lp) begin
            out_n   = '0;
            state_n = accum_r ? IDLE : CLEAR;
          end else begin
            out_n = out_r + out_w_lp'(1);
          end
        end
      end
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Flush wins over any same-cycle accept or yumi; those transfers are dropped.
    if (flush_i) begin
      state_n = CLEAR;
      lane_n  = '0;
      k_n     = '0;
      wait_n  = '0;
      out_n   = '0;
      k_len_n = k_len_r;
      accum_n = accum_r;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      lane_r  <= '0;
      k_r     <= '0;
      wait_r  <= '0;
      out_r   <= '0;
      k_len_r <= k_w_lp'(1);
      accum_r <= 1'b0;
    end else if (en_i) begin
      state_r <= state_n;
      lane_r  <= lane_n;
      k_r     <= k_n;
      wait_r  <= wait_n;
      out_r   <= out_n;
      k_len_r <= k_len_n;
      accum_r <= accum_n;
    end
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Testbench for systolic_tile_sequencer with a 2x2 array, max_k_p=4,
// drain_lat_p=4. Inputs change at the falling edge; outputs are sampled
// 1 time unit later, well before the next rising edge.
module tb_systolic_tile_sequencer;

  localparam int width_p = 16;
  localparam int aw_p    = 2;
  localparam int ah_p    = 2;
  localparam int max_k_p = 4;
  localparam int lat_p   = 4;
  localparam int kw_p    = $clog2(max_k_p + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic                        en_i = 1'b1;
  logic                        flush_i = 1'b0;
  logic [kw_p-1:0]             k_len_i = '0;
  logic                        accum_i = 1'b0;
  logic                        valid_i = 1'b0;
  logic [width_p-1:0]          data_i = '0;
  logic                        ready_o;
  logic [width_p*ah_p-1:0]     row_o;
  logic [ah_p-1:0]             row_valid_o;
  logic [ah_p-1:0]             row_ready_i = '1;
  logic [width_p*aw_p-1:0]     col_o;
  logic [aw_p-1:0]             col_valid_o;
  logic [aw_p-1:0]             col_ready_i = '1;
  logic                        mac_clear_o;
  logic [width_p*ah_p*aw_p-1:0] z_i = '0;
  logic                        valid_o;
  logic [width_p-1:0]          data_o;
  logic                        last_o;
  logic                        yumi_i = 1'b0;
  logic                        busy_o;
  logic [2:0]                  state_o;

  systolic_tile_sequencer #(
    .width_p(width_p), .array_width_p(aw_p), .array_height_p(ah_p),
    .max_k_p(max_k_p), .drain_lat_p(lat_p)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .k_len_i(k_len_i), .accum_i(accum_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .row_o(row_o), .row_valid_o(row_valid_o),
    .row_ready_i(row_ready_i), .col_o(col_o), .col_valid_o(col_valid_o),
    .col_ready_i(col_ready_i), .mac_clear_o(mac_clear_o), .z_i(z_i),
    .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .yumi_i(yumi_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  // scoreboard
  logic [width_p-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int tb_lane = 0;

  always @(negedge clk) if (mac_clear_o) clr_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {row_valid[1:0], col_valid[1:0]} for each lane index
  function automatic logic [3:0] lane_mask(input int l);
    case (l)
      0:       return 4'b0100;
      1:       return 4'b1000;
      2:       return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic int k_eff(input int k);
    if (k == 0) return 1;
    if (k > max_k_p) return max_k_p;
    return k;
  endfunction

  // driver: new z contents for a tile; expected results queued now
  task automatic load_z();
    logic [width_p-1:0] w;
    for (int i = 0; i < aw_p*ah_p; i++) begin
      w = width_p'($urandom_range(0, 65535));
      z_i[i*width_p +: width_p] = w;
      exp_q.push_back(w);
    end
  endtask

  // driver: one operand word, optionally stalling the selected lane first
  task automatic send_word(input logic [width_p-1:0] d, input int stall);
    logic [3:0] m;
    int guard;
    m = lane_mask(tb_lane);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = d;
    if (stall > 0) begin
      {row_ready_i, col_ready_i} = ~m;
      for (int i = 0; i < stall; i++) begin
        #1;
        check_eq("stall_ready", ready_o, 0);
        check_eq("stall_lane", {row_valid_o, col_valid_o}, m);
        @(negedge clk);
      end
      {row_ready_i, col_ready_i} = '1;
    end
    #1;
    guard = 0;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("accept_ready", ready_o, 1);
    check_eq("lane_mask", {row_valid_o, col_valid_o}, m);
    check_eq("row0_data", row_o[width_p-1:0], d);
    check_eq("col1_data", col_o[2*width_p-1 -: width_p], d);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    tb_lane = (tb_lane + 1) % (aw_p + ah_p);
  endtask

  task automatic send_tile(input int k_in, input logic acc, input int n_words, input int stall_at);
    int total;
    total = k_eff(k_in) * (aw_p + ah_p);
    k_len_i = kw_p'(k_in);
    accum_i = acc;
    for (int i = 0; i < n_words; i++) begin
      send_word(width_p'($urandom_range(1, 65535)), (i == stall_at) ? 3 : 0);
      check_eq("load_state", state_o, (i == total - 1) ? 2 : 1);
    end
  endtask

  // consumer: count WAIT cycles, drain and score the results, check the clear
  task automatic wait_and_drain(input logic acc, input int stall, input int en_gap);
    int wc, guard, got, clr0;
    logic [width_p-1:0] e;
    wc = 0; guard = 0; got = 0;
    clr0 = clr_cnt;
    @(negedge clk);
    while (state_o == 3'd2 && guard < 50) begin
      wc++; guard++;
      @(negedge clk);
    end
    check_eq("wait_cycles", wc, lat_p);
    #1;
    check_eq("drain_state", state_o, 3);
    if (en_gap > 0) begin
      en_i = 1'b0;
      for (int i = 0; i < en_gap; i++) begin
        #1;
        check_eq("en_low_valid", valid_o, 0);
        check_eq("en_low_state", state_o, 3);
        @(negedge clk);
      end
      en_i = 1'b1;
    end
    while (got < aw_p*ah_p && guard < 200) begin
      guard++;
      #1;
      check_eq("drain_valid", valid_o, 1);
      if (stall > 0 && got == 1) begin
        for (int i = 0; i < stall; i++) begin
          check_eq("hold_valid", valid_o, 1);
          check_eq("hold_data", data_o, exp_q[0]);
          @(negedge clk);
          #1;
        end
      end
      e = exp_q.pop_front();
      check_eq("result", data_o, e);
      check_eq("last", last_o, (got == aw_p*ah_p - 1));
      yumi_i = 1'b1;
      @(posedge clk);
      #1;
      yumi_i = 1'b0;
      got++;
      @(negedge clk);
    end
    #1;
    if (acc) begin
      check_eq("accum_state", state_o, 0);
      check_eq("accum_no_clear", clr_cnt - clr0, 0);
    end else begin
      check_eq("clear_state", state_o, 4);
      check_eq("clear_pulse", mac_clear_o, 1);
      @(negedge clk);
      #1;
      check_eq("post_clear_state", state_o, 0);
      check_eq("clear_count", clr_cnt - clr0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    check_eq("rst_state", state_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_clear", mac_clear_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_ready", ready_o, 1);
    @(negedge clk);
    reset_i = 1'b0;

    // basic tile, lane 1 backpressured for 3 cycles, output stalled 5 cycles
    load_z();
    send_tile(1, 1'b0, 4, 1);
    wait_and_drain(1'b0, 5, 0);

    // accumulate tile then a normal tile, with an enable gap in DRAIN
    load_z();
    send_tile(3, 1'b1, 12, -1);
    wait_and_drain(1'b1, 0, 3);
    load_z();
    send_tile(3, 1'b0, 12, -1);
    wait_and_drain(1'b0, 0, 0);

    // depth saturation (7 -> 4) and zero depth (0 -> 1)
    load_z();
    send_tile(7, 1'b0, 16, -1);
    wait_and_drain(1'b0, 0, 0);
    load_z();
    send_tile(0, 1'b0, 4, -1);
    wait_and_drain(1'b0, 0, 0);

    // flush during LOAD at k_idx=1, with a discarded same-cycle accept
    send_tile(3, 1'b0, 4, -1);
    @(negedge clk);
    flush_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    check_eq("flush_state", state_o, 4);
    check_eq("flush_clear", mac_clear_o, 1);
    @(posedge clk);
    #1;
    check_eq("flush_idle", state_o, 0);
    check_eq("flush_clear_off", mac_clear_o, 0);
    tb_lane = 0;
    load_z();
    send_tile(2, 1'b0, 8, -1);
    wait_and_drain(1'b0, 0, 0);

    // async reset in DRAIN, no clock edge involved
    load_z();
    send_tile(1, 1'b0, 4, -1);
    for (int i = 0; i < 20 && state_o != 3'd3; i++) @(negedge clk);
    #1;
    check_eq("pre_rst_valid", valid_o, 1);
    #1;
    reset_i = 1'b1;
    #1;
    check_eq("arst_valid", valid_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_state", state_o, 0);
    reset_i = 1'b0;
    exp_q.delete();
    tb_lane = 0;

    // a tile after reset still completes
    load_z();
    send_tile(1, 1'b0, 4, -1);
    wait_and_drain(1'b0, 0, 0);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
Parametrised successor to the current systolic array driver. It streams a tile of K operand steps from one ready/valid input into an external mac_array's row/column lanes using true per-lane handshakes, with no slow-enable workaround. It waits for the array pipeline to settle, then drains all H*W results over a valid/yumi producer port with a last flag. It supports variable K depth, accumulate-across-tiles mode and abort-by-flush. It sits between the host stream and mac_array, and replaces the reset-per-matrix scheme with an explicit mac_clear_o pulse.

Parameters:
width_p, 32, data word width
array_width_p, 8, columns W (>=1)
array_height_p, 8, rows H (>=1)
max_k_p, 16, maximum K steps per tile (>=1)
drain_lat_p, 16, cycles between the last operand accept and the first result read (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
en_i  in  1  global enable; low freezes all state and forces ready_o=0, valid_o=0
flush_i  in  1  abort current tile and clear the array
k_len_i  in  $clog2(max_k_p+1)  K steps for the next tile; sampled on the tile's first accept
accum_i  in  1  1 = keep MAC contents after drain; sampled on the tile's first accept
valid_i  in  1  input word valid
data_i  in  width_p  input word
ready_o  out  1  input word accepted when valid_i & ready_o
row_o  out  width_p*H  data_i replicated to every row lane
row_valid_o  out  H  row lane valid
row_ready_i  in  H  row lane ready
col_o  out  width_p*W  data_i replicated to every column lane
col_valid_o  out  W  column lane valid
col_ready_i  in  W  column lane ready
mac_clear_o  out  1  one-cycle clear to mac_array
z_i  in  width_p*H*W  MAC results; word r*W+c sits at bits [(r*W+c+1)*width_p-1 -: width_p]
valid_o  out  1  result valid
data_o  out  width_p  result word
last_o  out  1  current result is word H*W-1
yumi_i  in  1  result consumed
busy_o  out  1  state != IDLE
state_o  out  3  IDLE=0, LOAD=1, WAIT=2, DRAIN=3, CLEAR=4

Behaviour:
- Reset (async): state IDLE, all counters 0, k_len_r=1, accum_r=0. All outputs 0 except ready_o, which follows its equation.
- Lane order per K step: rows 0..H-1, then columns 0..W-1. lane_idx counts 0..H+W-1.
- Handshake is combinational pass-through, zero latency: the selected lane's valid = valid_i & en_i & (IDLE|LOAD); ready_o = en_i & (IDLE|LOAD) & the selected lane's ready. All other lane valids are 0.
- IDLE: the first accept samples k_len_i (0 is treated as 1; values above max_k_p saturate to max_k_p) and accum_i, advances lane_idx and goes to LOAD. If H+W=1 and k=1, go directly to WAIT.
- LOAD: each accept increments lane_idx; it wraps at H+W-1 and increments k_idx. An accept with lane_idx=H+W-1 and k_idx=k_len_r-1 goes to WAIT and clears both counters.
- WAIT: wait_cnt counts 1..drain_lat_p; at drain_lat_p go to DRAIN with out_idx=0. ready_o=0.
- DRAIN: valid_o=1 and data_o=z_i word out_idx; last_o=(out_idx==H*W-1). yumi_i advances out_idx. data_o is stable while valid_o is high and yumi_i is low. yumi_i on the last word goes to CLEAR if accum_r=0, else to IDLE. yumi_i while valid_o=0 is ignored.
- CLEAR: mac_clear_o=1 for exactly one cycle, then IDLE.
- flush_i (when en_i high) from any state: next state CLEAR, all counters 0. flush_i takes priority over accepts and yumi in the same cycle; that cycle's accept/yumi still handshakes but is discarded. flush_i in CLEAR keeps CLEAR one more cycle.
- Outside DRAIN: data_o=0, last_o=0. mac_clear_o=0 outside CLEAR.
- en_i low mid-operation: no counter or state change; resumes exactly when en_i returns.

Test Plan:
- H=W=2, drain_lat_p=4, k_len_i=1, accum_i=0: send 4 words 1,2,3,4 -> row_valid_o pulses 01,10, then col_valid_o 01,10. 4 WAIT cycles, then data_o = z words 0..3 in order, last_o on word 3, one mac_clear_o pulse, state back to 0.
- Lane backpressure: hold row_ready_i[1]=0 for 3 cycles while on lane 1 -> ready_o=0 for those 3 cycles, lane_idx unchanged, no word lost.
- k_len_i=3, accum_i=1, then a second tile with accum_i=0 -> 12 accepts per tile. No mac_clear_o after tile 1; exactly one mac_clear_o after tile 2.
- Output backpressure: yumi_i low for 5 cycles in DRAIN -> valid_o stays 1 and data_o stays constant. out_idx advances only on yumi_i.
- flush_i asserted during LOAD at k_idx=1 -> next cycle state_o=4 with mac_clear_o=1, then IDLE. A fresh tile afterwards completes normally.
- Async reset pulsed mid-DRAIN with no clock edge -> valid_o and busy_o drop immediately, state_o=0.
